// File: rtl/output_port_arbiter.sv
// Purpose: per-output-port round-robin packet allocator with downstream credit gating and crossbar select.
// Latency: eligible header at cycle t is latched as owner; first grant at t+1 earliest; grant is combinational.
// Backpressure: grant withheld while owner FIFO is empty or credits are 0; the FSM holds, so no flit is lost.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   req[NUM_REQ]      per-input route bit for this output
//   empty[NUM_REQ]    per-input FIFO empty flag
//   flit_type         head-flit type per input, slice i = [3*i +: 3]
//   credit_in         one-cycle pulse, downstream freed one slot
//   grant             one-hot read enable to the owner's FIFO (combinational)
//   xbar_sel          registered index of the current owner
//   valid_out         a flit crosses this output this cycle (|grant)
//   busy              packet in progress (LOCKED)
//   credit_err        sticky credit overflow flag
// Optional: define OUTPUT_PORT_ARBITER_CREDIT_CHECK_EN to build the credit overflow check;
//   otherwise credit_err is tied to 0.

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef BODY
`define BODY 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

module output_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int SEL_W   = 2,
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   empty,
  input  logic [3*NUM_REQ-1:0] flit_type,
  input  logic                 credit_in,
  output logic [NUM_REQ-1:0]   grant,
  output logic [SEL_W-1:0]     xbar_sel,
  output logic                 valid_out,
  output logic                 busy,
  output logic                 credit_err
);

  localparam logic [1:0]       IDLE     = 2'b00;
  localparam logic [1:0]       LOCKED   = 2'b01;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]         state_q, state_d;
  logic [SEL_W-1:0]   owner_q, owner_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   credit_cnt_q, credit_cnt_d;

  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [SEL_W-1:0]   pick;
  logic [2:0]         owner_type;
  logic               credit_ok;
  logic               grant_any;
  logic               tail_grant;

  // Index arithmetic modulo NUM_REQ without a divider.
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return SEL_W'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req[i] & ~empty[i] & (flit_type[3*i +: 3] == `HEADER);
    end
  end

  // First eligible requester scanning from rr_ptr upward with wrap.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && eligible[wrap_add(rr_ptr_q, k)]) begin
        found = 1'b1;
        pick  = wrap_add(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    owner_type = 3'b000;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == SEL_W'(i)) owner_type = flit_type[3*i +: 3];
    end
  end

  assign credit_ok = (credit_cnt_q != '0);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = (state_q == LOCKED) & (owner_q == SEL_W'(i)) & ~empty[i] & credit_ok;
    end
  end

  assign grant_any  = |grant;
  assign tail_grant = grant_any & (owner_type == `TAIL);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOCKED;
          owner_d = pick;
        end
      end
      LOCKED: begin
        if (tail_grant) begin
          state_d  = IDLE;
          rr_ptr_d = wrap_add(owner_q, 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A grant and a returning credit in the same cycle cancel out.
  always_comb begin
    credit_cnt_d = credit_cnt_q;
    if (grant_any && !credit_in) begin
      credit_cnt_d = credit_cnt_q - CNT_ONE;
    end else if (!grant_any && credit_in && (credit_cnt_q != CNT_FULL)) begin
      credit_cnt_d = credit_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      credit_cnt_q <= CNT_FULL;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      credit_cnt_q <= credit_cnt_d;
    end
  end

  assign xbar_sel  = owner_q;
  assign valid_out = grant_any;
  assign busy      = (state_q == LOCKED);

`ifdef OUTPUT_PORT_ARBITER_CREDIT_CHECK_EN
  logic credit_err_q, credit_err_d;

  // A credit with the counter full and no flit consumed means downstream returned more than it was given.
  assign credit_err_d = credit_err_q | (credit_in & ~grant_any & (credit_cnt_q == CNT_FULL));

  always_ff @(posedge clk) begin
    if (rst) credit_err_q <= 1'b0;
    else     credit_err_q <= credit_err_d;
  end

  assign credit_err = credit_err_q;
`else
  assign credit_err = 1'b0;
`endif

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- Per-output-port allocator placed after the LBDR stage of each input port.
- Collects the route-request bit for this output from every input port and grants one requester in round-robin order.
- Holds the grant for the whole packet, from HEADER through TAIL.
- Gates every flit transfer on downstream credits and drives the crossbar select for this output.

Parameters:
- NUM_REQ, 3, number of input ports that may request this output.
- SEL_W, 2, width of xbar_sel; 2^SEL_W >= NUM_REQ.
- CREDITS, 4, downstream buffer depth; reset value of the credit counter.
- CNT_W, 3, credit counter width; 2^CNT_W > CREDITS.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-input route bit for this output (LBDR port output).
- empty  input  NUM_REQ  per-input FIFO empty flag.
- flit_type  input  3*NUM_REQ  head-flit type of each input FIFO; slice i = [3*i +: 3]; `HEADER/`BODY/`TAIL codes.
- credit_in  input  1  one-cycle pulse; downstream freed one slot.
- grant  output  NUM_REQ  one-hot read enable to the owner's FIFO (combinational).
- xbar_sel  output  SEL_W  index of the current owner (registered).
- valid_out  output  1  a flit crosses this output this cycle; equals |grant.
- busy  output  1  high in LOCKED.
- credit_err  output  1  sticky overflow flag; only meaningful with the optional feature.

Behaviour:
- Reset values (registered):
  - state=IDLE, owner/xbar_sel=0, rr_ptr=0, credit_cnt=CREDITS, credit_err=0.
  - grant=0, valid_out=0, busy=0 follow from these.
- Eligibility: requester i is eligible when req[i] & ~empty[i] & (flit_type slice i == `HEADER).
- IDLE:
  - If any requester is eligible, choose the first eligible index scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Latch it into owner/xbar_sel and go to LOCKED next cycle.
  - No grant is issued in IDLE.
  - No eligible requester: stay in IDLE.
- LOCKED:
  - grant[owner] = ~empty[owner] & (credit_cnt != 0); all other grant bits are 0.
  - Requests from non-owners are ignored.
  - A granted flit whose type is `TAIL causes: next state IDLE; rr_ptr = owner+1 (wraps NUM_REQ-1 -> 0).
  - A granted HEADER or BODY flit keeps the state in LOCKED.
- Latency:
  - An eligible header at cycle t is granted at cycle t+1 at the earliest (if credits > 0 and the FIFO is still non-empty).
  - The first grant for the next packet comes no earlier than 2 cycles after its TAIL grant (IDLE cycle, then LOCKED).
- Credit counter:
  - Decrements on each grant cycle; increments on each credit_in.
  - Grant and credit_in in the same cycle: counter unchanged.
  - At 0: grant is held low, state is unchanged (stall), and no flit is lost.
  - Saturates at CREDITS: a credit_in while full leaves the counter at CREDITS.
- Owner FIFO empty mid-packet: grant low, stay in LOCKED, resume when non-empty.
- rst asserted mid-packet: returns to reset values on the next edge. The partial packet is abandoned; upstream flushing is outside this block.
- FSM has only IDLE and LOCKED; any illegal encoding returns to IDLE.

Optional Feature:
- Macro: OUTPUT_PORT_ARBITER_CREDIT_CHECK_EN.
- Defined: credit_in arriving when credit_cnt == CREDITS and no grant is issued that cycle sets credit_err=1. It stays set until rst.
- Undefined: credit_err is tied to 0 and no check logic is synthesized. Counter saturation behaviour is identical in both builds.

Test Plan:
- Single packet:
  - Stimulus: req=3'b001, input 0 holds HEADER, BODY, TAIL; credits 4.
  - Response: xbar_sel=0 one cycle after the header appears; grant=3'b001 for 3 consecutive cycles; IDLE after TAIL; credit_cnt=1; rr_ptr=1.
- Round-robin fairness:
  - Stimulus: all three inputs hold 2-flit packets from cycle 0; credit_in returned each cycle.
  - Response: owners are granted in order 0, 1, 2, 0; no grant to a non-owner while busy=1.
- Credit stall:
  - Stimulus: CREDITS=4; input 1 sends a 6-flit packet; no credit_in until cycle 10.
  - Response: 4 grants, then grant=0 with busy=1; a credit_in pulse yields exactly one further grant.
- Simultaneous credit and grant:
  - Stimulus: credit_in pulsed on every grant cycle.
  - Response: credit_cnt stays at 4 for the whole packet.
- Mid-packet reset:
  - Stimulus: rst pulsed after a BODY grant.
  - Response: next cycle state=IDLE, grant=0, credit_cnt=4, xbar_sel=0, rr_ptr=0.
- Credit overflow (feature enabled):
  - Stimulus: credit_in with counter=4 and idle.
  - Response: credit_err=1 and stays set; counter stays 4. With the feature disabled, credit_err stays 0.
